// File: rtl/usb_fs_out_pe_pp.sv
// USB full-speed OUT protocol engine with ping-pong (two-slot) receive buffers per endpoint.
// Handles OUT/SETUP tokens, data toggle checking, ACK/NAK/STALL handshakes and a granted read port.
module usb_fs_out_pe_pp #(
  parameter int NUM_OUT_EPS         = 1,
  parameter int MAX_OUT_PACKET_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_OUT_EPS-1:0] reset_ep,
  input  logic [6:0]             dev_addr,
  output logic [NUM_OUT_EPS-1:0] out_ep_data_avail,
  output logic [NUM_OUT_EPS-1:0] out_ep_setup,
  input  logic [NUM_OUT_EPS-1:0] out_ep_grant,
  input  logic [NUM_OUT_EPS-1:0] out_ep_data_get,
  output logic [7:0]             out_ep_data,
  output logic [6:0]             out_ep_len,
  input  logic [NUM_OUT_EPS-1:0] out_ep_release,
  input  logic [NUM_OUT_EPS-1:0] out_ep_stall,
  output logic [NUM_OUT_EPS-1:0] out_ep_acked,
  input  logic                   rx_pkt_start,
  input  logic                   rx_pkt_end,
  input  logic                   rx_pkt_valid,
  input  logic [3:0]             rx_pid,
  input  logic [6:0]             rx_addr,
  input  logic [3:0]             rx_endp,
  input  logic [10:0]            rx_frame_num,
  input  logic                   rx_data_put,
  input  logic [7:0]             rx_data,
  output logic                   tx_pkt_start,
  output logic [3:0]             tx_pid,
  input  logic                   tx_pkt_end
);
  localparam int N   = NUM_OUT_EPS;
  localparam int M   = MAX_OUT_PACKET_SIZE;
  localparam int EPW = (N > 1) ? $clog2(N) : 1;
  localparam int AW  = $clog2(M);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TOKEN = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_HS    = 2'd3;

  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  logic [1:0]     state_q, state_d;
  logic [EPW-1:0] ep_q, ep_d;
  logic           nak_q, nak_d;
  logic           ovf_q, ovf_d;
  logic           dtog_q, dtog_d;
  logic [6:0]     cnt_q, cnt_d;

  logic [N-1:0][1:0]      full_q;
  logic [N-1:0][1:0][6:0] len_q;
  logic [N-1:0][6:0]      rptr_q;
  logic [N-1:0]           wslot_q, rslot_q, tog_q, stall_q, setup_q;
  logic [7:0]             data_q;
  logic [7:0]             mem_q [N][2][M];

  logic           tok_acc, tok_setup, hs_live, stalled, mismatch, commit, wr_en;
  logic [EPW-1:0] tok_ep, gidx;
  logic [3:0]     pid_sel;
  logic [N-1:0]   avail;
  logic           unused_ok;

  assign unused_ok = ^{rx_frame_num, tx_pkt_end};

  assign tok_ep    = rx_endp[EPW-1:0];
  assign tok_setup = (rx_pid[3:2] == 2'b11);
  assign tok_acc   = (state_q == ST_IDLE) && rx_pkt_end && rx_pkt_valid &&
                     (rx_pid[1:0] == 2'b01) && (rx_pid[3:2] == 2'b00 || tok_setup) &&
                     (rx_addr == dev_addr) && ({1'b0, rx_endp} < 5'(N));

  // Handshake outcome; a reset_ep landing in the handshake cycle silences it.
  assign hs_live  = (state_q == ST_HS) && !reset_ep[ep_q];
  assign stalled  = stall_q[ep_q] | out_ep_stall[ep_q];
  assign mismatch = (dtog_q != tog_q[ep_q]);
  assign commit   = hs_live && !stalled && !mismatch && !nak_q;

  always_comb begin
    pid_sel = PID_ACK;
    if (stalled)       pid_sel = PID_STALL;
    else if (mismatch) pid_sel = PID_ACK;
    else if (nak_q)    pid_sel = PID_NAK;
  end

  assign tx_pkt_start = hs_live;
  assign tx_pid       = hs_live ? pid_sel : 4'h0;

  always_comb begin
    out_ep_acked       = '0;
    out_ep_acked[ep_q] = commit;
  end

  always_comb begin
    state_d = state_q;
    ep_d    = ep_q;
    nak_d   = nak_q;
    ovf_d   = ovf_q;
    dtog_d  = dtog_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (tok_acc) begin
        state_d = ST_TOKEN;
        ep_d    = tok_ep;
        nak_d   = !tok_setup && full_q[tok_ep][wslot_q[tok_ep]];
      end
      ST_TOKEN: if (rx_pkt_start) begin
        state_d = ST_DATA;
        cnt_d   = 7'd0;
        ovf_d   = 1'b0;
      end
      ST_DATA: begin
        if (rx_data_put) begin
          if (cnt_q < 7'(M + 2)) cnt_d = cnt_q + 7'd1;
          else                   ovf_d = 1'b1;
        end
        if (rx_pkt_end) begin
          state_d = (rx_pkt_valid && rx_pid[2:0] == 3'b011 && !ovf_q && cnt_q >= 7'd2) ?
                    ST_HS : ST_IDLE;
          dtog_d  = rx_pid[3];
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && reset_ep[ep_q]) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ep_q    <= '0;
      nak_q   <= 1'b0;
      ovf_q   <= 1'b0;
      dtog_q  <= 1'b0;
      cnt_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      ep_q    <= ep_d;
      nak_q   <= nak_d;
      ovf_q   <= ovf_d;
      dtog_q  <= dtog_d;
      cnt_q   <= cnt_d;
    end
  end

  // A full write slot is never written, so NAKed packets cannot corrupt unread data.
  assign wr_en = (state_q == ST_DATA) && rx_data_put && !nak_q && (cnt_q < 7'(M));

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[ep_q][wslot_q[ep_q]][cnt_q[AW-1:0]] <= rx_data;
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      avail[i] = full_q[i][rslot_q[i]] && (rptr_q[i] < len_q[i][rslot_q[i]]);
  end
  assign out_ep_data_avail = avail;
  assign out_ep_setup      = setup_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q  <= '0;
      len_q   <= '0;
      rptr_q  <= '0;
      wslot_q <= '0;
      rslot_q <= '0;
      tog_q   <= '0;
      stall_q <= '0;
      setup_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (out_ep_data_get[i] && avail[i]) rptr_q[i] <= rptr_q[i] + 7'd1;
        if (out_ep_release[i] && full_q[i][rslot_q[i]]) begin
          full_q[i][rslot_q[i]] <= 1'b0;
          rptr_q[i]             <= 7'd0;
          rslot_q[i]            <= ~rslot_q[i];
        end
        if (out_ep_stall[i]) stall_q[i] <= 1'b1;
        if (commit && ep_q == EPW'(i)) begin
          full_q[i][wslot_q[i]] <= 1'b1;
          len_q[i][wslot_q[i]]  <= cnt_q - 7'd2;
          wslot_q[i]            <= ~wslot_q[i];
          tog_q[i]              <= ~tog_q[i];
        end
        if (tok_acc && tok_ep == EPW'(i)) begin
          setup_q[i] <= tok_setup;
          if (tok_setup) begin
            full_q[i]  <= 2'b00;
            rptr_q[i]  <= 7'd0;
            wslot_q[i] <= 1'b0;
            rslot_q[i] <= 1'b0;
            tog_q[i]   <= 1'b0;
            stall_q[i] <= 1'b0;
          end
        end
        if (reset_ep[i]) begin
          full_q[i]  <= 2'b00;
          len_q[i]   <= '0;
          rptr_q[i]  <= 7'd0;
          wslot_q[i] <= 1'b0;
          rslot_q[i] <= 1'b0;
          tog_q[i]   <= 1'b0;
          stall_q[i] <= 1'b0;
          setup_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++)
      if (out_ep_grant[i]) gidx = EPW'(i);
  end
  assign out_ep_len = len_q[gidx][rslot_q[gidx]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_q <= 8'h00;
    else          data_q <= mem_q[gidx][rslot_q[gidx]][rptr_q[gidx][AW-1:0]];
  end
  assign out_ep_data = data_q;

endmodule

// File: tb/tb_usb_fs_out_pe_pp.sv
// Bench for usb_fs_out_pe_pp: directed scenarios then random traffic against a
// packet-queue model of the endpoint FIFOs, toggles, stall and setup flags.
module tb_usb_fs_out_pe_pp;
  localparam int NEP = 2;
  localparam int MPS = 32;
  localparam logic [3:0] ACK   = 4'b0010;
  localparam logic [3:0] NAK   = 4'b1010;
  localparam logic [3:0] STALL = 4'b1110;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [NEP-1:0] reset_ep = '0, out_ep_grant = '0, out_ep_data_get = '0;
  logic [NEP-1:0] out_ep_release = '0, out_ep_stall = '0;
  logic [6:0]     dev_addr = 7'h00;
  logic [NEP-1:0] out_ep_data_avail, out_ep_setup, out_ep_acked;
  logic [7:0]     out_ep_data;
  logic [6:0]     out_ep_len;
  logic           rx_pkt_start = 1'b0, rx_pkt_end = 1'b0, rx_pkt_valid = 1'b0, rx_data_put = 1'b0;
  logic [3:0]     rx_pid = 4'h0, rx_endp = 4'h0;
  logic [6:0]     rx_addr = 7'h00;
  logic [10:0]    rx_frame_num = 11'h000;
  logic [7:0]     rx_data = 8'h00;
  logic           tx_pkt_start;
  logic [3:0]     tx_pid;
  logic           tx_pkt_end = 1'b0;

  always #5 clk = ~clk;

  usb_fs_out_pe_pp #(.NUM_OUT_EPS(NEP), .MAX_OUT_PACKET_SIZE(MPS)) dut (
    .clk(clk), .reset_n(reset_n), .reset_ep(reset_ep), .dev_addr(dev_addr),
    .out_ep_data_avail(out_ep_data_avail), .out_ep_setup(out_ep_setup),
    .out_ep_grant(out_ep_grant), .out_ep_data_get(out_ep_data_get),
    .out_ep_data(out_ep_data), .out_ep_len(out_ep_len),
    .out_ep_release(out_ep_release), .out_ep_stall(out_ep_stall),
    .out_ep_acked(out_ep_acked),
    .rx_pkt_start(rx_pkt_start), .rx_pkt_end(rx_pkt_end), .rx_pkt_valid(rx_pkt_valid),
    .rx_pid(rx_pid), .rx_addr(rx_addr), .rx_endp(rx_endp), .rx_frame_num(rx_frame_num),
    .rx_data_put(rx_data_put), .rx_data(rx_data),
    .tx_pkt_start(tx_pkt_start), .tx_pid(tx_pid), .tx_pkt_end(tx_pkt_end)
  );

  int tests = 0;
  int fails = 0;
  int acked_cnt = 0;

  always @(negedge clk) acked_cnt <= acked_cnt + $countones(out_ep_acked);

  // Reference model: committed packets in arrival order, tagged by endpoint.
  typedef struct {
    int               ep;
    int               len;
    logic [8*MPS-1:0] d;
  } pkt_t;
  pkt_t           mq[$];
  logic [NEP-1:0] mtog = '0, mstall = '0, msetup = '0;

  function automatic int mcount(input int ep);
    int c;
    c = 0;
    foreach (mq[i]) if (mq[i].ep == ep) c++;
    return c;
  endfunction

  function automatic int mhead(input int ep);
    for (int i = 0; i < mq.size(); i++) if (mq[i].ep == ep) return i;
    return -1;
  endfunction

  function automatic void mpurge(input int ep);
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].ep == ep) mq.delete(i);
    mtog[ep]   = 1'b0;
    mstall[ep] = 1'b0;
  endfunction

  function automatic logic [NEP-1:0] exp_avail();
    logic [NEP-1:0] v;
    int h;
    v = '0;
    for (int e = 0; e < NEP; e++) begin
      h = mhead(e);
      if (h >= 0 && mq[h].len > 0) v[e] = 1'b1;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tok(input bit setup, input int ep, input bit addr_ok);
    rx_pkt_end   = 1'b1;
    rx_pkt_valid = 1'b1;
    rx_pid       = setup ? 4'b1101 : 4'b0001;
    rx_addr      = addr_ok ? dev_addr : (dev_addr ^ 7'h05);
    rx_endp      = 4'(ep);
    cyc();
    rx_pkt_end   = 1'b0;
    rx_pkt_valid = 1'b0;
    rx_pid       = 4'h0;
    rx_pkt_start = 1'b1;
    cyc();
    rx_pkt_start = 1'b0;
  endtask

  task automatic send_bytes(input int n, input logic [8*MPS-1:0] pay);
    for (int j = 0; j < n; j++) begin
      rx_data_put = 1'b1;
      rx_data     = (j < MPS) ? pay[8*j +: 8] : 8'($urandom);
      cyc();
    end
    rx_data_put = 1'b0;
  endtask

  task automatic send_end(input bit dtog);
    rx_pkt_end   = 1'b1;
    rx_pkt_valid = 1'b1;
    rx_pid       = dtog ? 4'b1011 : 4'b0011;
    cyc();
    rx_pkt_end   = 1'b0;
    rx_pkt_valid = 1'b0;
    rx_pid       = 4'h0;
  endtask

  // Watches a bounded window for the handshake pulse.
  task automatic obs_hs(output bit got, output logic [3:0] pid);
    got = 1'b0;
    pid = 4'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (tx_pkt_start === 1'b1) begin
        got = 1'b1;
        pid = tx_pid;
        break;
      end
    end
    cyc();
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_avail"}, 32'(out_ep_data_avail), 32'(exp_avail()));
    chk({tag, "_setup"}, 32'(out_ep_setup), 32'(msetup));
  endtask

  task automatic xfer(input bit setup, input int ep, input bit dtog, input int npay,
                      input bit addr_ok, input string tag);
    logic [8*MPS-1:0] pay;
    logic [3:0]       ehs, pid;
    bit               commit, got;
    int               a0;
    pkt_t             p;
    for (int j = 0; j < MPS; j++) pay[8*j +: 8] = 8'($urandom);
    ehs    = 4'h0;
    commit = 1'b0;
    if (addr_ok) begin
      if (setup) begin
        mpurge(ep);
        msetup[ep] = 1'b1;
      end else msetup[ep] = 1'b0;
      if (npay > MPS)              ehs = 4'h0;
      else if (mstall[ep])         ehs = STALL;
      else if (dtog != mtog[ep])   ehs = ACK;
      else if (mcount(ep) == 2)    ehs = NAK;
      else begin
        ehs    = ACK;
        commit = 1'b1;
        p.ep   = ep;
        p.len  = npay;
        p.d    = pay;
        mq.push_back(p);
        mtog[ep] = ~mtog[ep];
      end
    end
    a0 = acked_cnt;
    send_tok(setup, ep, addr_ok);
    send_bytes(npay + 2, pay);
    send_end(dtog);
    obs_hs(got, pid);
    chk({tag, "_hs"}, 32'(got), 32'(ehs != 4'h0));
    if (got) chk({tag, "_pid"}, 32'(pid), 32'(ehs));
    chk({tag, "_acked"}, 32'(acked_cnt - a0), 32'(commit));
    check_status(tag);
  endtask

  task automatic read_pkt(input int ep, input string tag);
    int   h;
    pkt_t p;
    h = mhead(ep);
    out_ep_grant     = '0;
    out_ep_grant[ep] = 1'b1;
    cyc();
    cyc();
    if (h < 0) begin
      chk({tag, "_empty_avail"}, 32'(out_ep_data_avail[ep]), 32'd0);
      out_ep_release[ep] = 1'b1;
      cyc();
      out_ep_release = '0;
      check_status({tag, "_empty_rel"});
    end else begin
      p = mq[h];
      chk({tag, "_len"}, 32'(out_ep_len), 32'(p.len));
      chk({tag, "_avail0"}, 32'(out_ep_data_avail[ep]), 32'(p.len > 0));
      for (int j = 0; j < p.len; j++) begin
        chk({tag, "_data"}, 32'(out_ep_data), 32'(p.d[8*j +: 8]));
        out_ep_data_get[ep] = 1'b1;
        cyc();
        out_ep_data_get = '0;
        cyc();
      end
      chk({tag, "_avail_end"}, 32'(out_ep_data_avail[ep]), 32'd0);
      out_ep_release[ep] = 1'b1;
      cyc();
      out_ep_release = '0;
      mq.delete(h);
      check_status({tag, "_rel"});
    end
  endtask

  task automatic pulse_stall(input int ep);
    out_ep_stall[ep] = 1'b1;
    cyc();
    out_ep_stall = '0;
    mstall[ep] = 1'b1;
  endtask

  initial begin
    bit         got;
    logic [3:0] pid;
    int         a0, ep, r, np;
    bit         tg;

    dev_addr = 7'($urandom_range(127, 1));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_avail", 32'(out_ep_data_avail), 32'd0);
    chk("rst_setup", 32'(out_ep_setup), 32'd0);
    chk("rst_data", 32'(out_ep_data), 32'd0);
    chk("rst_len", 32'(out_ep_len), 32'd0);
    chk("rst_tx", 32'({tx_pkt_start, tx_pid}), 32'd0);
    chk("rst_acked", 32'(out_ep_acked), 32'd0);
    reset_n = 1'b1;
    cyc();

    // Ping-pong fill, NAK when both slots full, retry after release, duplicate DATA0.
    xfer(0, 0, 1'b0, 10, 1, "d0_10");
    xfer(0, 0, 1'b1, 12, 1, "d1_12");
    xfer(0, 0, 1'b0, 5, 1, "d0_nak");
    read_pkt(0, "rd_a");
    xfer(0, 0, 1'b0, 5, 1, "d0_retry");
    xfer(0, 0, 1'b0, 7, 1, "d0_dup");
    read_pkt(0, "rd_b");
    read_pkt(0, "rd_c");
    read_pkt(0, "rd_empty");

    // Length boundaries: zero-length, exactly max, one over, far over.
    xfer(0, 0, mtog[0], 0, 1, "zlp");
    read_pkt(0, "rd_zlp");
    xfer(0, 0, mtog[0], MPS, 1, "max");
    read_pkt(0, "rd_max");
    xfer(0, 0, mtog[0], MPS + 1, 1, "over1");
    xfer(0, 0, mtog[0], 38, 1, "over40");

    // Stall persists after the level drops, cleared by SETUP.
    pulse_stall(0);
    xfer(0, 0, mtog[0], 4, 1, "stall1");
    xfer(0, 0, mtog[0], 4, 1, "stall2");
    xfer(1, 0, 1'b0, 8, 1, "setup8");
    read_pkt(0, "rd_setup");

    // Second endpoint, foreign address, reset_ep in the middle of a transfer.
    xfer(0, 1, mtog[1], 4, 1, "ep1_pre");
    xfer(0, 1, mtog[1], 6, 0, "badaddr");
    a0 = acked_cnt;
    send_tok(0, 1, 1);
    send_bytes(3, '0);
    reset_ep[1] = 1'b1;
    cyc();
    reset_ep = '0;
    send_bytes(4, '0);
    send_end(mtog[1]);
    obs_hs(got, pid);
    mpurge(1);
    msetup[1] = 1'b0;
    chk("rstep_hs", 32'(got), 32'd0);
    chk("rstep_acked", 32'(acked_cnt - a0), 32'd0);
    check_status("rstep");
    xfer(0, 1, 1'b0, 3, 1, "ep1_post");
    read_pkt(1, "rd_ep1");

    for (int it = 0; it < 60; it++) begin
      ep = int'($urandom_range(NEP - 1, 0));
      r  = int'($urandom_range(99, 0));
      if (r < 3) pulse_stall(ep);
      else if (r < 10) xfer(1, ep, ($urandom_range(4, 0) == 0), int'($urandom_range(MPS, 0)), 1, "r_setup");
      else if (r < 35) read_pkt(ep, "r_read");
      else if (r < 40) xfer(0, ep, mtog[ep], 4, 0, "r_badaddr");
      else begin
        tg = ($urandom_range(3, 0) == 0) ? ~mtog[ep] : mtog[ep];
        np = ($urandom_range(9, 0) == 0) ? int'($urandom_range(40, MPS + 1)) : int'($urandom_range(MPS, 0));
        xfer(0, ep, tg, np, 1, "r_out");
      end
    end

    // Asynchronous reset during a data phase.
    xfer(1, 0, 1'b0, 10, 1, "pre_rst");
    out_ep_grant = 2'b01;
    cyc();
    cyc();
    send_tok(0, 1, 1);
    send_bytes(5, '0);
    rx_data_put = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    rx_data_put = 1'b0;
    chk("arst_avail", 32'(out_ep_data_avail), 32'd0);
    chk("arst_setup", 32'(out_ep_setup), 32'd0);
    chk("arst_data", 32'(out_ep_data), 32'd0);
    chk("arst_len", 32'(out_ep_len), 32'd0);
    chk("arst_tx", 32'({tx_pkt_start, tx_pid}), 32'd0);
    chk("arst_acked", 32'(out_ep_acked), 32'd0);
    mq.delete();
    mtog = '0;
    mstall = '0;
    msetup = '0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    cyc();
    xfer(0, 0, 1'b0, 6, 1, "post_rst");
    read_pkt(0, "rd_post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/usb_fs_out_pe_pp.md
USB_FS_OUT_PE_PP -- requirements
Module: usb_fs_out_pe_pp

Interface
REQ-001 Parameter NUM_OUT_EPS, default 1, number of OUT endpoints; legal 1..16.
REQ-002 Parameter MAX_OUT_PACKET_SIZE, default 32, bytes per buffer slot; legal 8, 16, 32, 64.
REQ-003 Port clk, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-004 Port reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port reset_ep, input, NUM_OUT_EPS, synchronous per-endpoint reset.
REQ-006 Port dev_addr, input, 7, device address.
REQ-007 Port out_ep_data_avail, output, NUM_OUT_EPS, granted read slot holds unread bytes.
REQ-008 Port out_ep_setup, output, NUM_OUT_EPS, last token to this endpoint was SETUP.
REQ-009 Port out_ep_grant, input, NUM_OUT_EPS, one-hot consumer select; all-zero selects endpoint 0.
REQ-010 Port out_ep_data_get, input, NUM_OUT_EPS, read strobe; advances the read pointer.
REQ-011 Port out_ep_data, output, 8, byte at the granted endpoint's read pointer.
REQ-012 Port out_ep_len, output, 7, payload length of the granted endpoint's read slot.
REQ-013 Port out_ep_release, input, NUM_OUT_EPS, one-cycle pulse freeing the current read slot.
REQ-014 Port out_ep_stall, input, NUM_OUT_EPS, level request to stall the endpoint.
REQ-015 Port out_ep_acked, output, NUM_OUT_EPS, one-cycle pulse when an ACK is issued for an accepted packet.
REQ-016 Ports rx_pkt_start, rx_pkt_end, rx_pkt_valid (1 each), rx_pid (4), rx_addr (7), rx_endp (4), rx_frame_num (11), rx_data_put (1), rx_data (8), inputs, receive-path strobes and fields; rx_frame_num is unused.
REQ-017 Ports tx_pkt_start (1), output; tx_pid (4), output; tx_pkt_end (1), input: transmit-path handshake.

Function
REQ-018 Each endpoint SHALL own two slots (ping-pong) of MAX_OUT_PACKET_SIZE bytes, each with a full flag and a 7-bit length, plus a write-slot pointer, a read-slot pointer and a data toggle bit.
REQ-019 A token SHALL be accepted when rx_pkt_end && rx_pkt_valid && rx_pid[1:0]==01 && rx_addr==dev_addr && rx_endp<NUM_OUT_EPS; rx_pid[3:2]==00 is OUT, 11 is SETUP.
REQ-020 Transfer FSM states: IDLE -> TOKEN on accepted token; TOKEN -> DATA on rx_pkt_start; DATA -> HANDSHAKE on a valid DATA0/1 end (rx_pid[2:0]==011); DATA -> IDLE with no handshake on an invalid or non-data end; HANDSHAKE -> IDLE after the one-cycle tx_pkt_start pulse.
REQ-021 In HANDSHAKE, tx_pid priority SHALL be: STALL (1110) if the endpoint is stalled; ACK (0010) with packet discarded on toggle mismatch; NAK (1010) if the write slot was full at token time; otherwise ACK, commit the slot and flip the toggle.
REQ-022 Commit SHALL set the slot full flag, store length = received bytes - 2 (CRC excluded), advance the write-slot pointer and pulse out_ep_acked for one cycle.
REQ-023 Bytes received beyond MAX_OUT_PACKET_SIZE+2 SHALL NOT be written; such a packet SHALL be discarded with no handshake.
REQ-024 A SETUP SHALL always be accepted: it clears both slots, both slot pointers and the stall state, forces the toggle to 0 before the data check, and sets out_ep_setup; an OUT token clears out_ep_setup.
REQ-025 Stall SHALL be held while out_ep_stall is high and SHALL persist after it falls until a SETUP is received.
REQ-026 out_ep_data SHALL be registered with one-cycle latency from the grant/pointer change.
REQ-027 out_ep_data_avail[i] SHALL be high when the read slot is full and the read pointer < length; zero-length packets SHALL have full=1 and avail=0.
REQ-028 out_ep_release SHALL clear the read slot, reset the read pointer and toggle the read-slot pointer; release of an empty slot SHALL be ignored.
REQ-029 Release and commit on the same endpoint in the same cycle SHALL both take effect.
REQ-030 Pointer and length arithmetic SHALL be 7-bit unsigned with no wrap beyond MAX_OUT_PACKET_SIZE.

Reset
REQ-031 reset_n low SHALL asynchronously drive all outputs to 0, the FSM to IDLE, all slots empty and all toggles to 0.
REQ-032 reset_ep[i] SHALL do the same for endpoint i only; if asserted mid-transfer on i, the transfer SHALL be discarded with no handshake.

Verification
REQ-033 OUT ep0 followed by DATA0 of 10 bytes -> ACK, len=10, avail=1, toggle=1, out_ep_acked pulses once.
REQ-034 Three DATA packets alternating DATA0/DATA1 with no release -> ACK, ACK, NAK; after one release, the retried packet is ACKed.
REQ-035 Repeated DATA0 after an ACKed DATA0 -> ACK, no slot change.
REQ-036 out_ep_stall pulsed, then OUT + DATA -> STALL; then SETUP + DATA0 of 8 bytes -> ACK, setup=1, stall cleared.
REQ-037 DATA of 40 bytes with MAX_OUT_PACKET_SIZE=32 -> no handshake, slot remains empty.
REQ-038 reset_n asserted mid-DATA -> all outputs 0 immediately; the next transfer succeeds with DATA0.
